regfile_sequencer: RTL and testbench

- Initiator-side engine that drives the register file's write port and read port 0 on behalf of debug and boot logic.
- Clear mode: zeroes an address range of architectural registers, one write per cycle.
- Dump mode: reads an address range and streams each (address, value) pair out over a valid/ready handshake.
- Sits between the register file and the debug/boot controller. It is muxed onto the register-file ports only while busy=1.

---
 rtl/regfile_sequencer.sv | 96 +++++++++
 tb/tb_regfile_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/regfile_sequencer.sv
// regfile_sequencer: clears or dumps a register-file address range on behalf of debug/boot logic
module regfile_sequencer #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] rf_rd_addr,
    input  logic [DATA_W-1:0] rf_rd_data,
    output logic              rf_wr_ena,
    output logic [ADDR_W-1:0] rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data
);
    typedef enum logic [2:0] {IDLE, CLEAR, RD, HOLD, FIN} state_t;
    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cur_q, cur_d, last_q, last_d, out_addr_q, out_addr_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                err_q, err_d;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cur_q      <= '0;
            last_q     <= '0;
            err_q      <= 1'b0;
            out_addr_q <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            last_q     <= last_d;
            err_q      <= err_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
        end
    end
    // Range end is detected by equality before incrementing, so cur never wraps.
    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        last_d     = last_q;
        err_d      = err_q;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;
        case (state_q)
            IDLE: if (start) begin
                if (first_addr <= last_addr) begin
                    cur_d   = first_addr;
                    last_d  = last_addr;
                    state_d = mode ? CLEAR : RD;
                end else begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end
            end
            CLEAR: begin
                state_d = (cur_q == last_q) ? FIN : CLEAR;
                cur_d   = (cur_q == last_q) ? cur_q : cur_q + 1'b1;
            end
            RD: begin
                out_data_d = rf_rd_data;
                out_addr_d = cur_q;
                state_d    = HOLD;
            end
            HOLD: if (out_ready) begin
                state_d = (cur_q == last_q) ? FIN : RD;
                cur_d   = (cur_q == last_q) ? cur_q : cur_q + 1'b1;
            end
            FIN: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    assign busy       = (state_q == CLEAR) || (state_q == RD) || (state_q == HOLD);
    assign done       = (state_q == FIN);
    assign err        = (state_q == FIN) && err_q;
    assign rf_wr_ena  = (state_q == CLEAR);
    assign rf_wr_addr = (state_q == CLEAR) ? cur_q : '0;
    assign rf_wr_data = '0;
    assign rf_rd_addr = (state_q == RD || state_q == HOLD) ? cur_q : '0;
    assign out_valid  = (state_q == HOLD);
    assign out_addr   = out_addr_q;
    assign out_data   = out_data_q;
endmodule

// File: tb/tb_regfile_sequencer.sv
// tb_regfile_sequencer: table-driven check of clear/dump operations against a register-file model
module tb_regfile_sequencer;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, mode = 1'b0, out_ready = 1'b0;
    logic [4:0]  first_addr = '0, last_addr = '0;
    logic        busy, done, err, rf_wr_ena, out_valid;
    logic [4:0]  rf_rd_addr, rf_wr_addr, out_addr;
    logic [31:0] rf_rd_data, rf_wr_data, out_data;
    logic        pl_en = 1'b0;
    logic [4:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;
    logic [31:0] rf [32];
    logic [31:0] exp_rf [32];
    int          n_chk = 0, n_fail = 0;

    typedef struct {
        logic       mode;
        logic [4:0] f, l;
        int         stall, restart_at;
        logic       exp_err;
        int         exp_busy, exp_wr, exp_xfer;
    } vec_t;
    vec_t vecs [10];

    regfile_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .first_addr(first_addr), .last_addr(last_addr),
        .busy(busy), .done(done), .err(err),
        .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
        .rf_wr_ena(rf_wr_ena), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data)
    );

    always #5 clk = ~clk;

    // Register file: x0 hardwired to zero, writes discarded for address 0.
    always @(posedge clk) begin
        if (pl_en) rf[pl_addr] <= pl_data;
        else if (rf_wr_ena && rf_wr_addr != 5'd0) rf[rf_wr_addr] <= rf_wr_data;
    end
    assign rf_rd_data = (rf_rd_addr == 5'd0) ? 32'd0 : rf[rf_rd_addr];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int i);
        return (i == 5) ? 32'hDEADBEEF : (i == 6) ? 32'h12345678 : (32'hA5A50000 | 32'(i));
    endfunction

    task automatic preload();
        exp_rf[0] = 32'd0;
        for (int i = 1; i < 32; i++) begin
            pl_en = 1'b1; pl_addr = 5'(i); pl_data = pat(i);
            exp_rf[i] = pat(i);
            cyc();
        end
        pl_en = 1'b0;
    endtask

    task automatic run_op(input vec_t v);
        int busy_n = 0, wr_n = 0, xfer_n = 0, done_at = -1, stall = v.stall;
        logic err_s = 1'b0;
        start = 1'b1; mode = v.mode; first_addr = v.f; last_addr = v.l;
        out_ready = (stall == 0);
        cyc();
        start = 1'b0;
        for (int k = 0; k < 200 && done_at < 0; k++) begin
            if (k == v.restart_at) begin
                start = 1'b1; mode = 1'b1; first_addr = 5'd0; last_addr = 5'd31;
            end else start = 1'b0;
            out_ready = (stall == 0);
            if (busy) busy_n++;
            if (rf_wr_ena) begin
                chk("wr_addr", 32'(rf_wr_addr), 32'(v.f) + 32'(wr_n));
                chk("wr_data", rf_wr_data, 32'd0);
                wr_n++;
            end
            if (out_valid) begin
                chk(stall > 0 ? "hold_addr" : "out_addr", 32'(out_addr), 32'(v.f) + 32'(xfer_n));
                chk(stall > 0 ? "hold_data" : "out_data", out_data, exp_rf[5'(32'(v.f) + 32'(xfer_n))]);
                if (stall > 0) stall--;
                else xfer_n++;
            end
            if (done) begin
                done_at = k;
                err_s = err;
            end
            cyc();
        end
        start = 1'b0;
        out_ready = 1'b0;
        chk("done_latency", 32'(done_at), 32'(v.exp_busy));
        chk("err", 32'(err_s), 32'(v.exp_err));
        chk("busy_cycles", 32'(busy_n), 32'(v.exp_busy));
        chk("write_count", 32'(wr_n), 32'(v.exp_wr));
        chk("xfer_count", 32'(xfer_n), 32'(v.exp_xfer));
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_after", 32'(busy), 32'd0);
        if (v.mode && !v.exp_err)
            for (int i = int'(v.f); i <= int'(v.l); i++) exp_rf[i] = 32'd0;
    endtask

    initial begin
        int wr_n, done_n;
        //         mode  f      l      stall rst_at err   busy wr  xfer
        vecs[0] = '{1'b0, 5'd5,  5'd6,  0,  -1, 1'b0, 4,  0,  2};
        vecs[1] = '{1'b0, 5'd5,  5'd5,  10, -1, 1'b0, 12, 0,  1};
        vecs[2] = '{1'b0, 5'd5,  5'd6,  0,  2,  1'b0, 4,  0,  2};
        vecs[3] = '{1'b0, 5'd30, 5'd31, 3,  -1, 1'b0, 7,  0,  2};
        vecs[4] = '{1'b1, 5'd9,  5'd3,  0,  -1, 1'b1, 0,  0,  0};
        vecs[5] = '{1'b0, 5'd9,  5'd3,  0,  -1, 1'b1, 0,  0,  0};
        vecs[6] = '{1'b1, 5'd31, 5'd31, 0,  -1, 1'b0, 1,  1,  0};
        vecs[7] = '{1'b0, 5'd0,  5'd0,  0,  -1, 1'b0, 2,  0,  1};
        vecs[8] = '{1'b1, 5'd0,  5'd31, 0,  -1, 1'b0, 32, 32, 0};
        vecs[9] = '{1'b0, 5'd0,  5'd31, 0,  -1, 1'b0, 64, 0,  32};

        repeat (3) cyc();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_wr_ena", 32'(rf_wr_ena), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_rd_addr", 32'(rf_rd_addr), 32'd0);
        chk("rst_wr_addr", 32'(rf_wr_addr), 32'd0);
        chk("rst_out_addr", 32'(out_addr), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        rst = 1'b0;
        cyc();
        preload();
        for (int t = 0; t < 10; t++) begin
            run_op(vecs[t]);
            repeat (2) cyc();
        end

        // Reset during a full clear, asserted in the 10th write cycle (x9).
        preload();
        start = 1'b1; mode = 1'b1; first_addr = 5'd0; last_addr = 5'd31;
        cyc();
        start = 1'b0;
        wr_n = 0;
        for (int k = 0; k < 50 && wr_n < 10; k++) begin
            if (rf_wr_ena) wr_n++;
            if (wr_n == 10) rst = 1'b1;
            else cyc();
        end
        chk("writes_before_rst", 32'(wr_n), 32'd10);
        cyc();
        rst = 1'b0;
        chk("abort_wr_ena", 32'(rf_wr_ena), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        done_n = 0;
        for (int k = 0; k < 5; k++) begin
            if (done || rf_wr_ena) done_n++;
            cyc();
        end
        chk("abort_no_done", 32'(done_n), 32'd0);
        for (int i = 0; i < 10; i++) exp_rf[i] = 32'd0;
        run_op('{1'b0, 5'd0, 5'd31, 0, -1, 1'b0, 64, 0, 32});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
